// File: rtl/hub75_bcm_ctrl_pkg.sv
// ============================================================================
//  Module      : hub75_bcm_ctrl_pkg
//  Description : Shared definitions for the HUB75 binary-coded-modulation
//                controller: FSM state enumeration and clog2-derived width
//                helpers/constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hub75_bcm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LATCH = 3'd3,
        ST_SHOW  = 3'd4
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The longest plane needs BASE_T<<(depth-1) cycles; that value is a
    // power-of-two multiple of BASE_T, so one extra bit is needed to hold it.
    function automatic int oe_timer_width(input int base_t, input int depth);
        return $clog2(base_t << (depth - 1)) + 1;
    endfunction

    // Widths for the default build (2 x 64 columns, 1/16 scan, 8-bit colour,
    // BASE_T = 8).
    localparam int C_DEF_ADDR_W = addr_width(2 * 64 * 16);
    localparam int C_DEF_ROW_W  = addr_width(16);
    localparam int C_DEF_TMR_W  = oe_timer_width(8, 8);

endpackage

`default_nettype wire

// File: rtl/hub75_gamma_lut.sv
// ============================================================================
//  Module      : hub75_gamma_lut
//  Description : Fixed gamma-2.2 lookup for one colour channel, one register
//                stage. Only instantiated when HUB75_GAMMA_EN is defined.
//                The curve uses y = (4*x^2 + x^3/M) / (5*M) with M = full
//                scale, a close integer fit of M*(x/M)^2.2 that maps 0->0
//                and M->M.
//  Ports       : clk  - clock
//                din  - linear channel value
//                dout - gamma-corrected value, one cycle after din
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_gamma_lut #(
    parameter int PIXEL_DEPTH = 8
) (
    input  logic                   clk,
    input  logic [PIXEL_DEPTH-1:0] din,
    output logic [PIXEL_DEPTH-1:0] dout
);

    localparam int C_ENTRIES = 1 << PIXEL_DEPTH;

    function automatic logic [PIXEL_DEPTH-1:0] gamma_entry(input int x);
        longint m;
        longint lx;
        longint num;
        longint den;
        longint y;
        m   = (longint'(1) << PIXEL_DEPTH) - 1;
        lx  = longint'(x);
        num = 4 * lx * lx * m + lx * lx * lx;
        den = 5 * m * m;
        y   = (num + den / 2) / den;
        return PIXEL_DEPTH'(y);
    endfunction

    logic [PIXEL_DEPTH-1:0] w_table [C_ENTRIES];

    for (genvar i = 0; i < C_ENTRIES; i++) begin : g_entry
        assign w_table[i] = gamma_entry(i);
    end

    always_ff @(posedge clk) begin
        dout <= w_table[din];
    end

endmodule

`default_nettype wire

// File: rtl/hub75_bcm_ctrl.sv
// ============================================================================
//  Module      : hub75_bcm_ctrl
//  Description : HUB75 LED panel driver using binary-coded modulation. For
//                each row pair, bit planes 0..PIXEL_DEPTH-1 are shifted out
//                column by column, latched, and shown for BASE_T<<plane
//                cycles; shifting of the next plane overlaps the display.
//  Macro       : HUB75_GAMMA_EN - pass every channel through a gamma-2.2
//                lookup (one extra cycle of read-ahead).
//  Ports       : clk, rst (sync, active-high), en (run enable)
//                ram_addr/ram_rd/ram_data - frame buffer read port,
//                  data {uR,uG,uB,lR,lG,lB} valid RAM_LAT cycles after ram_rd
//                sclk, lat, oe_n (active-low) - panel control
//                rgb1/rgb2 - upper/lower {r,g,b}; row_addr - row select
//                frame_done - one-cycle pulse on the final latch of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_bcm_ctrl
    import hub75_bcm_ctrl_pkg::*;
#(
    parameter int NUM_PANELS  = 2,
    parameter int PANEL_W     = 64,
    parameter int SCAN_ROWS   = 16,
    parameter int PIXEL_DEPTH = 8,
    parameter int BASE_T      = 8,
    parameter int RAM_LAT     = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 en,
    output logic [addr_width(NUM_PANELS*PANEL_W*SCAN_ROWS)-1:0]  ram_addr,
    output logic                                                 ram_rd,
    input  logic [6*PIXEL_DEPTH-1:0]                             ram_data,
    output logic                                                 sclk,
    output logic                                                 lat,
    output logic                                                 oe_n,
    output logic [2:0]                                           rgb1,
    output logic [2:0]                                           rgb2,
    output logic [addr_width(SCAN_ROWS)-1:0]                     row_addr,
    output logic                                                 frame_done
);

    localparam int C_IMG_W   = NUM_PANELS * PANEL_W;
    localparam int C_ADDR_W  = addr_width(C_IMG_W * SCAN_ROWS);
    localparam int C_ROW_W   = addr_width(SCAN_ROWS);
    localparam int C_PLANE_W = addr_width(PIXEL_DEPTH);
    localparam int C_TMR_W   = oe_timer_width(BASE_T, PIXEL_DEPTH);
`ifdef HUB75_GAMMA_EN
    localparam int C_GAMMA_LAT = 1;
`else
    localparam int C_GAMMA_LAT = 0;
`endif
    // ram_rd -> channel data usable, and ram_rd -> rgb outputs updated.
    localparam int   C_DLY       = RAM_LAT + C_GAMMA_LAT;
    localparam int   C_LEAD      = C_DLY + 1;
    // Reads go out on even counts; sclk trails them by C_LEAD cycles, so a
    // plane occupies 2*IMG_W + C_LEAD cycles with no stall between columns.
    localparam int   C_SHIFT_LEN = 2 * C_IMG_W + C_LEAD;
    localparam int   C_CNT_W     = addr_width(C_SHIFT_LEN);
    localparam logic C_LEAD_ODD  = 1'(C_LEAD % 2);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [C_CNT_W-1:0]     r_k;
    logic [C_ROW_W-1:0]     r_row;       // row being shifted
    logic [C_PLANE_W-1:0]   r_plane;     // plane being shifted
    logic [C_ROW_W-1:0]     r_row_addr;  // row being displayed
    logic [C_TMR_W-1:0]     r_timer;
    logic [2:0]             r_rgb1;
    logic [2:0]             r_rgb2;
    logic [C_DLY-1:0]       r_rd_pipe;

    logic w_k_inc, w_k_clr, w_cnt_clr, w_adv, w_load, w_lat, w_done;
    logic w_last_plane, w_last_row, w_cap;

    logic [PIXEL_DEPTH-1:0] w_ch [6];

    assign w_last_plane = (r_plane == C_PLANE_W'(PIXEL_DEPTH - 1));
    assign w_last_row   = (r_row   == C_ROW_W'(SCAN_ROWS - 1));

    // ------------------------------------------------------------------
    // Channel data: raw or gamma-corrected. Channel 0 is upper R (MSBs).
    // ------------------------------------------------------------------
`ifdef HUB75_GAMMA_EN
    for (genvar i = 0; i < 6; i++) begin : g_gamma
        hub75_gamma_lut #(
            .PIXEL_DEPTH (PIXEL_DEPTH)
        ) u_lut (
            .clk  (clk),
            .din  (ram_data[(6-i)*PIXEL_DEPTH-1 -: PIXEL_DEPTH]),
            .dout (w_ch[i])
        );
    end
`else
    for (genvar i = 0; i < 6; i++) begin : g_raw
        assign w_ch[i] = ram_data[(6-i)*PIXEL_DEPTH-1 -: PIXEL_DEPTH];
    end
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_k_inc     = 1'b0;
        w_k_clr     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_adv       = 1'b0;
        w_load      = 1'b0;
        w_lat       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (r_k == C_CNT_W'(C_SHIFT_LEN - 1)) begin
                    w_state_nxt = ST_WAIT;
                    w_k_clr     = 1'b1;
                end else begin
                    w_k_inc     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (r_timer == '0) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_lat       = 1'b1;
                w_done      = w_last_plane && w_last_row;
                w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                // The latched plane is always shown; en only decides
                // whether another plane gets shifted behind it.
                w_load = 1'b1;
                if (en) begin
                    w_adv       = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift counter, plane/row sequencing, displayed row
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_cnt_clr || w_k_clr) begin
            r_k <= '0;
        end else if (w_k_inc) begin
            r_k <= r_k + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_cnt_clr) begin
            r_row   <= '0;
            r_plane <= '0;
        end else if (w_adv) begin
            if (w_last_plane) begin
                r_plane <= '0;
                r_row   <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_plane <= r_plane + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_addr <= '0;
        end else if (w_lat && (r_plane == '0)) begin
            r_row_addr <= r_row;
        end
    end

    // ------------------------------------------------------------------
    // OE timer: loaded in SHOW, counts down; oe_n is low while nonzero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_load) begin
            r_timer <= C_TMR_W'(BASE_T) << r_plane;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read tracking and rgb capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe[0] <= ram_rd;
            for (int i = 1; i < C_DLY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    assign w_cap = r_rd_pipe[C_DLY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb1 <= '0;
            r_rgb2 <= '0;
        end else if (w_cap) begin
            r_rgb1 <= {w_ch[0][r_plane], w_ch[1][r_plane], w_ch[2][r_plane]};
            r_rgb2 <= {w_ch[3][r_plane], w_ch[4][r_plane], w_ch[5][r_plane]};
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state
    // ------------------------------------------------------------------
    assign ram_rd     = (r_state == ST_SHIFT) && (r_k < C_CNT_W'(2 * C_IMG_W)) && !r_k[0];
    assign ram_addr   = C_ADDR_W'(r_row) * C_ADDR_W'(C_IMG_W) + C_ADDR_W'(r_k >> 1);
    assign sclk       = (r_state == ST_SHIFT) && (r_k >= C_CNT_W'(C_LEAD)) && (r_k[0] != C_LEAD_ODD);
    assign lat        = w_lat;
    assign frame_done = w_done;
    assign oe_n       = (r_timer == '0);
    assign rgb1       = r_rgb1;
    assign rgb2       = r_rgb2;
    assign row_addr   = r_row_addr;

endmodule

`default_nettype wire

// File: doc/hub75_bcm_ctrl.md
HUB75_BCM_CTRL -- requirements
Module: hub75_bcm_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst; rst is synchronous and active-high.
REQ-002 Parameter NUM_PANELS, 2, panels chained horizontally.
REQ-003 Parameter PANEL_W, 64, columns per panel.
REQ-004 Parameter SCAN_ROWS, 16, row pairs per panel (1/16 scan).
REQ-005 Parameter PIXEL_DEPTH, 8, bits per colour channel.
REQ-006 Parameter BASE_T, 8, clk cycles of OE-on time for bit plane 0.
REQ-007 Parameter RAM_LAT, 1, clk cycles from ram_rd to valid ram_data (1..3).
REQ-008 Ports: clk in 1 clock; rst in 1 reset; en in 1 run enable.
REQ-009 Ports: ram_addr out clog2(NUM_PANELS*PANEL_W*SCAN_ROWS) word address; ram_rd out 1 read strobe; ram_data in 6*PIXEL_DEPTH {upper R,G,B, lower R,G,B}, MSB first.
REQ-010 Ports: sclk out 1 shift clock; lat out 1 latch; oe_n out 1 output enable, active-low.
REQ-011 Ports: rgb1 out 3 upper {r,g,b}; rgb2 out 3 lower {r,g,b}; row_addr out clog2(SCAN_ROWS) row select; frame_done out 1 one-cycle pulse.

Function
REQ-012 Modulation SHALL be binary-coded: for each row and bit plane b (0..PIXEL_DEPTH-1), rgb bits equal bit b of each channel, displayed for BASE_T<<b cycles.
REQ-013 FSM states: IDLE, SHIFT, WAIT, LATCH, SHOW; IDLE->SHIFT when en=1.
REQ-014 SHIFT: each column takes 2 cycles (sclk=0 with rgb updated, then sclk=1); IMG_W = NUM_PANELS*PANEL_W columns per plane.
REQ-015 ram_addr SHALL equal row*IMG_W + col; reads SHALL be issued RAM_LAT cycles ahead so sclk never stalls within a plane.
REQ-016 After the last column: SHIFT->WAIT; WAIT holds until the OE timer of the previous plane expires (immediately if none running).
REQ-017 LATCH: one cycle with oe_n=1 and lat=1; row_addr SHALL change only in this cycle, and only when latching plane 0 of a new row.
REQ-018 SHOW: load OE timer with BASE_T<<b, drive oe_n=0 while timer>0, enter SHIFT for the next plane the following cycle (shifting overlaps display).
REQ-019 Order: plane 0..PIXEL_DEPTH-1 per row, rows 0..SCAN_ROWS-1; after the last plane of the last row, frame_done pulses on its LATCH cycle and row wraps to 0.
REQ-020 en deasserted mid-frame SHALL complete the current plane's display, then go IDLE with oe_n=1; restart SHALL begin at row 0, plane 0.
REQ-021 OE timer width SHALL be clog2(BASE_T<<(PIXEL_DEPTH-1))+1 bits; no overflow permitted.

Reset
REQ-022 While rst=1: state IDLE, sclk=0, lat=0, oe_n=1, rgb1=rgb2=0, row_addr=0, ram_rd=0, ram_addr=0, frame_done=0, timer=0.
REQ-023 rst asserted mid-operation SHALL take effect on the next edge, blanking the panel immediately.

Configuration
REQ-024 Macro HUB75_GAMMA_EN defined: each channel value SHALL pass through a fixed gamma-2.2 lookup (PIXEL_DEPTH in, PIXEL_DEPTH out) before bit-plane selection, adding 1 cycle to read-ahead.
REQ-025 HUB75_GAMMA_EN undefined: channel values SHALL be used unmodified; no lookup logic present.

Structure
REQ-026 A shared package SHALL hold the FSM state enumeration and the clog2-derived width constants.
REQ-027 The gamma table SHALL be a sub-module hub75_gamma_lut, instantiated six times under HUB75_GAMMA_EN.

Verification (NUM_PANELS=1, PANEL_W=4, SCAN_ROWS=2, PIXEL_DEPTH=2, BASE_T=4, RAM_LAT=1)
REQ-028 Reset: rst=1 for 3 cycles -> oe_n=1, lat=0, sclk=0, row_addr=0, all rgb 0.
REQ-029 All pixels 0x3F/0x3F (R=G=B=3) -> rgb1=rgb2=3'b111 every column; oe_n low 4 cycles plane 0, 8 cycles plane 1.
REQ-030 Pixel col2 upper R=2 only -> rgb1=3'b100 on col2 for plane 1 only; 0 elsewhere.
REQ-031 Full frame -> 4 sclk rising edges per plane, lat pulses 4 times, row_addr 0,0,1,1, frame_done once then row_addr back to 0.
REQ-032 en dropped during row 1 shifting -> current display completes, oe_n=1, IDLE; en=1 -> ram_addr restarts at 0.
REQ-033 rst during SHOW -> oe_n=1 on the next cycle.
